pwm_channel_bank: RTL and testbench

//  Memory-mapped bank of NUM_CH PWM channels; generalised successor of the fixed 8-output PWM path in synth_top.

---
 rtl/synth_pwm_pkg.sv | 29 ++
 rtl/pwm_compare_channel.sv | 46 ++++
 rtl/pwm_channel_bank.sv | 181 ++++++++++++++++++
 tb/tb_pwm_channel_bank.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/synth_pwm_pkg.sv
// Shared definitions for the PWM channel bank: register map offsets,
// CTRL bit positions and the counter mode / direction encodings.
package synth_pwm_pkg;

  // Register offsets relative to BASE_ADDR
  localparam int OFF_CTRL   = 0;
  localparam int OFF_PERIOD = 1;
  localparam int OFF_ENMASK = 2;
  localparam int OFF_STATUS = 3;
  localparam int OFF_DUTY0  = 4;

  // CTRL register bit indices
  localparam int CTRL_RUN    = 0;
  localparam int CTRL_CENTRE = 1;
  localparam int CTRL_INV    = 2;

  // Counter alignment mode
  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTRE = 1'b1
  } pwm_mode_e;

  // Counter direction, also reported in STATUS above the counter value
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } cnt_dir_e;

endpackage

// File: rtl/pwm_compare_channel.sv
// One PWM channel: shadow and active duty registers, the duty comparator
// and the registered output bit.
module pwm_compare_channel
  import synth_pwm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_io,
  input  logic             reset_io,
  input  logic             duty_we,
  input  logic [CNT_W-1:0] duty_wdata,
  input  logic             load,
  input  logic [CNT_W-1:0] cnt_p0,
  input  logic             run,
  input  logic             en,
  input  logic             inv,
  output logic [CNT_W-1:0] duty_shadow,
  output logic             pwm_p1
);

  logic [CNT_W-1:0] duty_act;
  logic [CNT_W-1:0] duty_nxt;
  logic             raw;

  // A write in the same cycle as a load goes straight through to active.
  assign duty_nxt = duty_we ? duty_wdata : duty_shadow;

  // Duty 0 never beats the counter; duty above the period always does.
  assign raw = (cnt_p0 < duty_act);

  // Shadow/active duty update and registered output (one cycle after counter).
  always_ff @(posedge clk_io or negedge reset_io) begin
    if (!reset_io) begin
      duty_shadow <= '0;
      duty_act    <= '0;
      pwm_p1      <= 1'b0;
    end else begin
      duty_shadow <= duty_nxt;
      if (load) begin
        duty_act <= duty_nxt;
      end
      pwm_p1 <= run & en & (raw ^ inv);
    end
  end

endmodule

// File: rtl/pwm_channel_bank.sv
// Memory-mapped bank of NUM_CH PWM channels sharing one up/down counter.
// Period, duty and the centre-mode bit are double-buffered and swap into
// their active copies at each period boundary (or every cycle while stopped).
module pwm_channel_bank
  import synth_pwm_pkg::*;
#(
  parameter int                NUM_CH    = 8,
  parameter int                CNT_W     = 8,
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 10'h3E0
) (
  input  logic              clk_io,
  input  logic              reset_io,
  input  logic              wr_en_io,
  input  logic              rd_en_io,
  input  logic [ADDR_W-1:0] addr_io,
  input  logic [DATA_W-1:0] wr_data_io,
  output logic [DATA_W-1:0] rd_data_io,
  output logic              period_irq_io,
  output logic [NUM_CH-1:0] pwm_io
);

  // Addresses below BASE_ADDR wrap to large offsets and fall outside the map.
  logic [ADDR_W-1:0] off;
  assign off = addr_io - BASE_ADDR;

  logic wr_ctrl, wr_period, wr_enmask;
  assign wr_ctrl   = wr_en_io && (off == ADDR_W'(OFF_CTRL));
  assign wr_period = wr_en_io && (off == ADDR_W'(OFF_PERIOD));
  assign wr_enmask = wr_en_io && (off == ADDR_W'(OFF_ENMASK));

  // Upper write-data bits beyond each field are intentionally dropped.
  logic unused_wr_bits;
  assign unused_wr_bits = ^wr_data_io;

  logic              ctrl_run, ctrl_centre, ctrl_inv;
  pwm_mode_e         centre_act;
  logic [CNT_W-1:0]  period_sh, period_act;
  logic [NUM_CH-1:0] enmask;

  logic [CNT_W-1:0]  cnt_p0, cnt_nxt;
  cnt_dir_e          dir, dir_nxt;
  logic              boundary;
  logic              load;

  logic [CNT_W-1:0]  period_nxt;
  logic              centre_nxt;

  assign period_nxt = wr_period ? wr_data_io[CNT_W-1:0] : period_sh;
  assign centre_nxt = wr_ctrl ? wr_data_io[CTRL_CENTRE] : ctrl_centre;
  assign load       = !ctrl_run || boundary;

  // Control, period and enable registers; active copies follow the shadows on load.
  always_ff @(posedge clk_io or negedge reset_io) begin
    if (!reset_io) begin
      ctrl_run    <= 1'b0;
      ctrl_centre <= 1'b0;
      ctrl_inv    <= 1'b0;
      centre_act  <= MODE_EDGE;
      period_sh   <= '0;
      period_act  <= '0;
      enmask      <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_run    <= wr_data_io[CTRL_RUN];
        ctrl_centre <= wr_data_io[CTRL_CENTRE];
        ctrl_inv    <= wr_data_io[CTRL_INV];
      end
      period_sh <= period_nxt;
      if (wr_enmask) begin
        enmask <= wr_data_io[NUM_CH-1:0];
      end
      if (load) begin
        period_act <= period_nxt;
        centre_act <= pwm_mode_e'(centre_nxt);
      end
    end
  end

  // Next counter value, direction and period-boundary detection.
  always_comb begin
    cnt_nxt  = cnt_p0;
    dir_nxt  = dir;
    boundary = 1'b0;
    if (!ctrl_run) begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
    end else if (period_act == '0) begin
      cnt_nxt  = '0;
      dir_nxt  = DIR_UP;
      boundary = 1'b1;
    end else if (centre_act == MODE_EDGE) begin
      dir_nxt = DIR_UP;
      if (cnt_p0 >= period_act) begin
        cnt_nxt  = '0;
        boundary = 1'b1;
      end else begin
        cnt_nxt = cnt_p0 + CNT_W'(1);
      end
    end else begin
      if (dir == DIR_UP && cnt_p0 < period_act) begin
        cnt_nxt = cnt_p0 + CNT_W'(1);
      end else if (cnt_p0 <= CNT_W'(1)) begin
        cnt_nxt  = '0;
        dir_nxt  = DIR_UP;
        boundary = 1'b1;
      end else begin
        cnt_nxt = cnt_p0 - CNT_W'(1);
        dir_nxt = DIR_DOWN;
      end
    end
  end

  // Shared counter state and the registered period interrupt pulse.
  always_ff @(posedge clk_io or negedge reset_io) begin
    if (!reset_io) begin
      cnt_p0        <= '0;
      dir           <= DIR_UP;
      period_irq_io <= 1'b0;
    end else begin
      cnt_p0        <= cnt_nxt;
      dir           <= dir_nxt;
      period_irq_io <= boundary;
    end
  end

  logic [CNT_W-1:0] duty_sh [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic duty_we;
    assign duty_we = wr_en_io && (off == ADDR_W'(OFF_DUTY0 + i));

    pwm_compare_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_io      (clk_io),
      .reset_io    (reset_io),
      .duty_we     (duty_we),
      .duty_wdata  (wr_data_io[CNT_W-1:0]),
      .load        (load),
      .cnt_p0      (cnt_p0),
      .run         (ctrl_run),
      .en          (enmask[i]),
      .inv         (ctrl_inv),
      .duty_shadow (duty_sh[i]),
      .pwm_p1      (pwm_io[i])
    );
  end

  logic [DATA_W-1:0] rd_mux;

  // Readback selection; shadow copies are returned for PERIOD and DUTY.
  always_comb begin
    rd_mux = '0;
    if (off == ADDR_W'(OFF_CTRL)) begin
      rd_mux = DATA_W'({ctrl_inv, ctrl_centre, ctrl_run});
    end else if (off == ADDR_W'(OFF_PERIOD)) begin
      rd_mux = DATA_W'(period_sh);
    end else if (off == ADDR_W'(OFF_ENMASK)) begin
      rd_mux = DATA_W'(enmask);
    end else if (off == ADDR_W'(OFF_STATUS)) begin
      rd_mux = DATA_W'({dir, cnt_p0});
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (off == ADDR_W'(OFF_DUTY0 + i)) begin
        rd_mux = DATA_W'(duty_sh[i]);
      end
    end
  end

  // Registered read data, held while no read is requested.
  always_ff @(posedge clk_io or negedge reset_io) begin
    if (!reset_io) begin
      rd_data_io <= '0;
    end else if (rd_en_io) begin
      rd_data_io <= rd_mux;
    end
  end

endmodule

// File: tb/tb_pwm_channel_bank.sv
// Directed bench for pwm_channel_bank: edge and centre modes, double
// buffering, duty bounds, bus map behaviour and asynchronous reset.
module tb_pwm_channel_bank;

  localparam int                NUM_CH = 8;
  localparam int                CNT_W  = 8;
  localparam int                DATA_W = 16;
  localparam int                ADDR_W = 10;
  localparam logic [ADDR_W-1:0] BASE   = 10'h3E0;

  localparam logic [ADDR_W-1:0] A_CTRL   = BASE + 10'd0;
  localparam logic [ADDR_W-1:0] A_PERIOD = BASE + 10'd1;
  localparam logic [ADDR_W-1:0] A_ENMASK = BASE + 10'd2;
  localparam logic [ADDR_W-1:0] A_STATUS = BASE + 10'd3;
  localparam logic [ADDR_W-1:0] A_DUTY0  = BASE + 10'd4;
  localparam logic [ADDR_W-1:0] A_DUTY1  = BASE + 10'd5;
  localparam logic [ADDR_W-1:0] A_DUTY7  = BASE + 10'd11;
  localparam logic [ADDR_W-1:0] A_PAST   = BASE + 10'd12;
  localparam logic [ADDR_W-1:0] A_BELOW  = BASE - 10'd1;

  logic              clk_io     = 1'b0;
  logic              reset_io   = 1'b0;
  logic              wr_en_io   = 1'b0;
  logic              rd_en_io   = 1'b0;
  logic [ADDR_W-1:0] addr_io    = '0;
  logic [DATA_W-1:0] wr_data_io = '0;
  logic [DATA_W-1:0] rd_data_io;
  logic              period_irq_io;
  logic [NUM_CH-1:0] pwm_io;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_io = ~clk_io;

  pwm_channel_bank #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)
  ) dut (
    .clk_io        (clk_io),
    .reset_io      (reset_io),
    .wr_en_io      (wr_en_io),
    .rd_en_io      (rd_en_io),
    .addr_io       (addr_io),
    .wr_data_io    (wr_data_io),
    .rd_data_io    (rd_data_io),
    .period_irq_io (period_irq_io),
    .pwm_io        (pwm_io)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // All bus tasks start right after a falling edge and end on the next one.
  task automatic bus_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en_io = 1'b1; addr_io = a; wr_data_io = d;
    @(negedge clk_io);
    wr_en_io = 1'b0;
  endtask

  task automatic bus_rd(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
    rd_en_io = 1'b1; addr_io = a;
    @(negedge clk_io);
    rd_en_io = 1'b0;
    d = rd_data_io;
  endtask

  task automatic bus_rdwr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                          output logic [DATA_W-1:0] rd);
    rd_en_io = 1'b1; wr_en_io = 1'b1; addr_io = a; wr_data_io = wd;
    @(negedge clk_io);
    rd_en_io = 1'b0; wr_en_io = 1'b0;
    rd = rd_data_io;
  endtask

  // Bit k of each pattern is the value seen on the (k+1)-th following falling edge.
  task automatic sample(input int n, input int b, output logic [31:0] pp, output logic [31:0] ip);
    pp = '0; ip = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk_io);
      pp[k] = pwm_io[b];
      ip[k] = period_irq_io;
    end
  endtask

  task automatic wait_irq(input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk_io);
      seen = period_irq_io;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0] rd;
    logic [31:0]       pp, ip;

    // Reset state
    repeat (3) @(negedge clk_io);
    check("rst_pwm", 32'(pwm_io), 32'h0);
    check("rst_irq", 32'(period_irq_io), 32'h0);
    check("rst_rd", 32'(rd_data_io), 32'h0);
    reset_io = 1'b1;
    @(negedge clk_io);
    bus_rd(A_STATUS, rd); check("rst_status", 32'(rd), 32'h0);
    bus_rd(A_PERIOD, rd); check("rst_period", 32'(rd), 32'h0);

    // Edge mode: P=9, D=3 -> 3 high of 10, irq every 10 cycles
    bus_wr(A_ENMASK, 16'h0001);
    bus_wr(A_PERIOD, 16'h0009);
    bus_wr(A_DUTY0, 16'h0003);
    bus_wr(A_CTRL, 16'h0001);
    sample(20, 0, pp, ip);
    check("edge_pwm", pp, 32'h01C07);
    check("edge_irq", ip, 32'h80200);

    // Mid-period duty write: rest of this period at 3, next period at 7
    bus_wr(A_DUTY0, 16'h0007);
    sample(20, 0, pp, ip);
    check("dbuf_mid", pp, 32'h8FE03);

    // Write landing on the boundary cycle is used for the very next period
    wait_irq("dbuf_sync");
    repeat (9) @(negedge clk_io);
    bus_wr(A_DUTY0, 16'h0005);
    sample(10, 0, pp, ip);
    check("dbuf_bound", pp, 32'h0001F);
    bus_rd(A_DUTY0, rd); check("dbuf_rd", 32'(rd), 32'h5);

    // Centre mode: P=4, D=2 -> counter 0,1,2,3,4,3,2,1; high while counter<2
    bus_wr(A_CTRL, 16'h0000);
    bus_wr(A_PERIOD, 16'h0004);
    bus_wr(A_DUTY0, 16'h0002);
    bus_wr(A_CTRL, 16'h0003);
    sample(16, 0, pp, ip);
    check("ctr_pwm", pp, 32'h8383);
    check("ctr_irq", ip, 32'h8080);
    repeat (5) @(negedge clk_io);
    bus_rd(A_STATUS, rd); check("ctr_status", 32'(rd), 32'h103);

    // Duty bounds, inversion and enable mask
    bus_wr(A_CTRL, 16'h0000);
    bus_wr(A_PERIOD, 16'h0009);
    bus_wr(A_DUTY0, 16'h0000);
    bus_wr(A_DUTY1, 16'h000A);
    bus_wr(A_ENMASK, 16'h0003);
    bus_wr(A_CTRL, 16'h0001);
    sample(12, 0, pp, ip); check("bnd_d0", pp, 32'h000);
    sample(12, 1, pp, ip); check("bnd_d10", pp, 32'hFFF);
    bus_wr(A_CTRL, 16'h0005);
    sample(12, 0, pp, ip); check("inv_d0", pp, 32'hFFF);
    sample(12, 1, pp, ip); check("inv_d10", pp, 32'h000);
    bus_wr(A_ENMASK, 16'h0002);
    sample(12, 0, pp, ip); check("mask_inv", pp, 32'h000);

    // Bus map: truncation, unmapped reads/writes, read-during-write
    bus_wr(A_DUTY7, 16'hFFAB);
    bus_rd(A_DUTY7, rd); check("bus_duty7", 32'(rd), 32'h00AB);
    bus_rd(A_PAST, rd); check("bus_unmapped_rd", 32'(rd), 32'h0);
    bus_wr(A_PAST, 16'h0055);
    bus_wr(A_BELOW, 16'h0055);
    bus_wr(A_STATUS, 16'hFFFF);
    bus_rd(A_CTRL, rd);   check("bus_ctrl", 32'(rd), 32'h5);
    bus_rd(A_PERIOD, rd); check("bus_period", 32'(rd), 32'h9);
    bus_rd(A_ENMASK, rd); check("bus_enmask", 32'(rd), 32'h2);
    bus_rd(A_DUTY7, rd);  check("bus_duty7_kept", 32'(rd), 32'h00AB);
    bus_rd(A_DUTY0, rd);  check("bus_duty0_kept", 32'(rd), 32'h0);
    bus_rdwr(A_ENMASK, 16'h0001, rd); check("bus_rdwr_old", 32'(rd), 32'h2);
    bus_rd(A_ENMASK, rd); check("bus_rdwr_new", 32'(rd), 32'h1);
    bus_wr(A_PERIOD, 16'h0012);
    bus_rd(A_PERIOD, rd); check("bus_period_shadow", 32'(rd), 32'h12);

    // Asynchronous reset while running with irq high
    wait_irq("rst_sync");
    check("pre_rst_pwm", 32'(pwm_io), 32'h01);
    check("pre_rst_rd", 32'(rd_data_io), 32'h12);
    #2 reset_io = 1'b0;
    #1;
    check("arst_pwm", 32'(pwm_io), 32'h0);
    check("arst_irq", 32'(period_irq_io), 32'h0);
    check("arst_rd", 32'(rd_data_io), 32'h0);
    @(negedge clk_io);
    reset_io = 1'b1;
    bus_rd(A_CTRL, rd);   check("post_ctrl", 32'(rd), 32'h0);
    bus_rd(A_PERIOD, rd); check("post_period", 32'(rd), 32'h0);
    bus_rd(A_ENMASK, rd); check("post_enmask", 32'(rd), 32'h0);
    bus_rd(A_DUTY1, rd);  check("post_duty1", 32'(rd), 32'h0);
    bus_rd(A_DUTY7, rd);  check("post_duty7", 32'(rd), 32'h0);

    // Outputs idle until RUN; then P=0 gives irq every cycle and duty 1 gives constant high
    bus_wr(A_ENMASK, 16'h0001);
    bus_wr(A_DUTY0, 16'h0001);
    sample(8, 0, pp, ip);
    check("idle_pwm", pp, 32'h00);
    check("idle_irq", ip, 32'h00);
    bus_wr(A_CTRL, 16'h0001);
    sample(8, 0, pp, ip);
    check("p0_pwm", pp, 32'hFF);
    check("p0_irq", ip, 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
